// File: rtl/blockade_video_out.sv
// blockade_video_out: Blockade-family video output stage.
// Tracks active-area coordinates, applies the colour-overlay film and emits aligned RGB/sync.

module blockade_video_out #(
  parameter int PIPE_DEPTH = 2,
  parameter int DIM_SHIFT  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic [1:0] game_mode,
  input  logic       overlay_en,
  input  logic       dim,
  input  logic       video_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       hblank_in,
  input  logic       vblank_in,
  output logic [7:0] r_out,
  output logic [7:0] g_out,
  output logic [7:0] b_out,
  output logic       hs_out,
  output logic       vs_out,
  output logic       hb_out,
  output logic       vb_out,
  output logic       de_out,
  output logic [7:0] x_pos,
  output logic [7:0] y_pos
);

  typedef struct packed {
    logic hs;
    logic vs;
    logic hb;
    logic vb;
  } tmg_t;

  typedef struct packed {
    logic       video;
    logic [1:0] mode;
    logic       ov;
    logic [1:0] band;
  } px_t;

  localparam tmg_t TMG_RST = '{hs: 1'b0, vs: 1'b0, hb: 1'b1, vb: 1'b1};
  localparam px_t  PX_RST  = '{video: 1'b0, mode: 2'd0, ov: 1'b0, band: 2'd0};

  logic [7:0]  x;
  logic [7:0]  y;
  logic        hblank_last;
  logic        hblank_rise;
  tmg_t        tmg [PIPE_DEPTH];
  px_t         px0;
  logic        dim_active;
  logic        vblank_rise;
  logic        lit;
  logic [23:0] band_rgb;
  logic [23:0] pix_rgb;
  logic [23:0] dim_rgb;
  logic [23:0] rgb_q;

  function automatic logic [23:0] band_colour(
    input logic [1:0] mode,
    input logic       ov,
    input logic [1:0] band
  );
    logic [23:0] c;
    c = 24'hFFFFFF;
    if (ov) begin
      case (mode)
        2'd1: begin
          case (band)
            2'd0:    c = 24'hFF0000;
            2'd1:    c = 24'hFFFF00;
            2'd2:    c = 24'h00FF00;
            default: c = 24'h00FFFF;
          endcase
        end
        2'd2: begin
          if (band == 2'd0 || band == 2'd3)
            c = 24'h00FF00;
        end
        2'd3: begin
          if (band == 2'd0)
            c = 24'hFFFF00;
          else if (band == 2'd3)
            c = 24'hFF00FF;
        end
        default: c = 24'hFFFFFF;
      endcase
    end
    return c;
  endfunction

  assign hblank_rise = hblank_in & ~hblank_last;

  // x saturates so a runaway line never wraps back into band 0
  always_ff @(posedge clk) begin
    if (reset) begin
      x           <= '0;
      y           <= '0;
      hblank_last <= 1'b1;
    end else if (ce_pix) begin
      if (hblank_in)
        x <= '0;
      else if (x != 8'hFF)
        x <= x + 8'd1;
      if (vblank_in)
        y <= '0;
      else if (hblank_rise)
        y <= y + 8'd1;
      hblank_last <= hblank_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE_DEPTH; i++)
        tmg[i] <= TMG_RST;
    end else if (ce_pix) begin
      tmg[0] <= '{hs: hsync_in, vs: vsync_in,
                  hb: hblank_in, vb: vblank_in};
      for (int i = 1; i < PIPE_DEPTH; i++)
        tmg[i] <= tmg[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      px0 <= PX_RST;
    end else if (ce_pix) begin
      px0 <= '{video: video_in, mode: game_mode,
               ov: overlay_en, band: x[7:6]};
    end
  end

  always_comb begin
    band_rgb = band_colour(px0.mode, px0.ov, px0.band);
    lit      = px0.video & ~(tmg[0].hb | tmg[0].vb);
    pix_rgb  = lit ? band_rgb : 24'h000000;
    dim_rgb  = pix_rgb;
    if (dim_active)
      dim_rgb = {pix_rgb[23:16] >> DIM_SHIFT,
                 pix_rgb[15:8]  >> DIM_SHIFT,
                 pix_rgb[7:0]   >> DIM_SHIFT};
  end

  // dim only switches on a frame boundary to avoid mid-frame tearing
  assign vblank_rise = tmg[0].vb & ~tmg[PIPE_DEPTH-1].vb;

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q      <= '0;
      dim_active <= 1'b0;
    end else if (ce_pix) begin
      rgb_q <= dim_rgb;
      if (vblank_rise)
        dim_active <= dim;
    end
  end

  assign {r_out, g_out, b_out} = rgb_q;
  assign hs_out = tmg[PIPE_DEPTH-1].hs;
  assign vs_out = tmg[PIPE_DEPTH-1].vs;
  assign hb_out = tmg[PIPE_DEPTH-1].hb;
  assign vb_out = tmg[PIPE_DEPTH-1].vb;
  assign de_out = ~(hb_out | vb_out);
  assign x_pos  = x;
  assign y_pos  = y;

endmodule
